// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronizes the raw lines, deframes 11-bit frames,
// and queues valid scan-code bytes in a show-ahead FIFO with a ready/nextdata_n pop.
module ps2_rx_fifo #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       sampling,
  output logic       frame_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  logic [2:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    data_sync_q, data_sync_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [10:0]   bits_q, bits_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          done_q, done_d;
  logic          sampling_q, sampling_d;
  logic          frame_err_q, frame_err_d;
  logic          overflow_q, overflow_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [DEPTH];

  logic fall, timeout, frame_ok, push;
  logic empty, full, pop, write, drop;

  always_comb begin
    clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    fall        = clk_sync_q[2] & ~clk_sync_q[1];
  end

  // Bit slot counter doubles as the IDLE/RECV state; the watchdog only runs mid-frame.
  always_comb begin
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    wdog_d  = wdog_q;
    done_d  = 1'b0;
    timeout = 1'b0;
    if (fall) begin
      bits_d[cnt_q] = data_sync_q[1];
      wdog_d        = '0;
      if (cnt_q == 4'd10) begin
        cnt_d  = 4'd0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end else if (cnt_q != 4'd0) begin
      if (wdog_q == WD_LAST) begin
        timeout = 1'b1;
        cnt_d   = 4'd0;
        wdog_d  = '0;
      end else begin
        wdog_d = wdog_q + WW'(1);
      end
    end
  end

  always_comb begin
    frame_ok    = ~bits_q[0] & bits_q[10] & (^bits_q[9:1]);
    push        = done_q & frame_ok;
    sampling_d  = fall;
    frame_err_d = (done_q & ~frame_ok) | timeout;
  end

  // A write into a full FIFO still succeeds when the head is popped in the same cycle.
  always_comb begin
    empty      = (rd_ptr_q == wr_ptr_q);
    full       = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) && (rd_ptr_q[AW] != wr_ptr_q[AW]);
    pop        = ~nextdata_n & ~empty;
    write      = push & (~full | pop);
    drop       = push & full & ~pop;
    rd_ptr_d   = pop   ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    wr_ptr_d   = write ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (pop) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      cnt_q       <= '0;
      bits_q      <= '0;
      wdog_q      <= '0;
      done_q      <= 1'b0;
      sampling_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      cnt_q       <= cnt_d;
      bits_q      <= bits_d;
      wdog_q      <= wdog_d;
      done_q      <= done_d;
      sampling_q  <= sampling_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (write) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bits_q[8:1];
    end
  end

  assign data      = mem_q[rd_ptr_q[AW-1:0]];
  assign ready     = ~empty;
  assign overflow  = overflow_q;
  assign sampling  = sampling_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: a queue-based model of the receiver and FIFO is
// compared every cycle, alongside hand-computed expectations for each scenario.
module tb_ps2_rx_fifo;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 4096;
  localparam int HALF    = 20;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready, overflow, sampling, frame_err;

  int vectors = 0;
  int miscompares = 0;
  int n_samp = 0;
  int n_ferr = 0;

  always #5 clk = ~clk;

  ps2_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .clr(clr), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .nextdata_n(nextdata_n), .data(data), .ready(ready), .overflow(overflow),
    .sampling(sampling), .frame_err(frame_err)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a pin fall is accepted 3 posedges after it settles, a complete frame
  // takes effect one cycle later, and a stalled frame is dropped TIMEOUT cycles
  // after its last accepted edge.
  bit          model_on = 1'b0;
  logic [3:0]  hc = '1, hd = '1;
  logic [10:0] frame, pend_frame;
  int          nbits = 0, idle = 0;
  bit          pend = 1'b0;
  logic [7:0]  q[$];
  bit          m_ovf = 1'b0, m_samp = 1'b0, m_ferr = 1'b0;

  always @(posedge clk) begin
    if (clr) begin
      model_on = 1'b1;
      hc = '1; hd = '1;
      nbits = 0; idle = 0; pend = 1'b0;
      q.delete();
      m_ovf = 1'b0; m_samp = 1'b0; m_ferr = 1'b0;
    end else if (model_on) begin
      m_samp = 1'b0;
      m_ferr = 1'b0;
      if (nextdata_n == 1'b0 && q.size() > 0) begin
        void'(q.pop_front());
        m_ovf = 1'b0;
      end
      if (pend) begin
        pend = 1'b0;
        if (!pend_frame[0] && pend_frame[10] && (^pend_frame[9:1])) begin
          if (q.size() < DEPTH) q.push_back(pend_frame[8:1]);
          else m_ovf = 1'b1;
        end else begin
          m_ferr = 1'b1;
        end
      end
      hc = {hc[2:0], ps2_clk};
      hd = {hd[2:0], ps2_data};
      if (hc[3] && !hc[2]) begin
        m_samp = 1'b1;
        frame[nbits] = hd[2];
        nbits++;
        idle = 0;
        if (nbits == 11) begin
          pend = 1'b1;
          pend_frame = frame;
          nbits = 0;
        end
      end else if (nbits > 0) begin
        idle++;
        if (idle == TIMEOUT) begin
          nbits = 0;
          idle = 0;
          m_ferr = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check_output("ready", 32'(ready), 32'(q.size() != 0));
      check_output("overflow", 32'(overflow), 32'(m_ovf));
      check_output("sampling", 32'(sampling), 32'(m_samp));
      check_output("frame_err", 32'(frame_err), 32'(m_ferr));
      if (q.size() != 0) check_output("data", 32'(data), 32'(q[0]));
    end
    if (sampling) n_samp++;
    if (frame_err) n_ferr++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_pop();
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
    #1;
  endtask

  // Drives the first nb bits of a frame; with pop_at_end the consumer pops in the
  // very cycle the last bit is accepted.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nb, input bit pop_at_end);
    logic [10:0] f;
    bit popped;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    popped = 1'b0;
    for (int i = 0; i < nb; i++) begin
      ps2_data = f[i];
      tick(HALF);
      ps2_clk = 1'b0;
      for (int k = 0; k < HALF; k++) begin
        @(negedge clk);
        nextdata_n = 1'b1;
        if (pop_at_end && i == 10 && !popped && sampling) begin
          nextdata_n = 1'b0;
          popped = 1'b1;
        end
      end
      nextdata_n = 1'b1;
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(HALF);
    #1;
  endtask

  int base;

  initial begin
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    check_output("rst ready", 32'(ready), 32'd0);
    check_output("rst overflow", 32'(overflow), 32'd0);
    check_output("rst sampling", 32'(sampling), 32'd0);
    check_output("rst frame_err", 32'(frame_err), 32'd0);

    base = n_samp;
    send_frame(8'h1C, 1'b0, 11, 1'b0);
    check_output("t1 pulses", 32'(n_samp - base), 32'd11);
    check_output("t1 ready", 32'(ready), 32'd1);
    check_output("t1 data", 32'(data), 32'h1C);
    do_pop();
    check_output("t1 ready after pop", 32'(ready), 32'd0);

    base = n_ferr;
    send_frame(8'h1C, 1'b1, 11, 1'b0);
    check_output("t2 frame_err pulses", 32'(n_ferr - base), 32'd1);
    check_output("t2 ready", 32'(ready), 32'd0);
    send_frame(8'hF0, 1'b0, 11, 1'b0);
    check_output("t2 data", 32'(data), 32'hF0);
    do_pop();

    for (int b = 1; b <= 9; b++) send_frame(8'(b), 1'b0, 11, 1'b0);
    check_output("t3 overflow", 32'(overflow), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      check_output("t3 drain data", 32'(data), 32'(i));
      do_pop();
      if (i == 1) check_output("t3 overflow cleared", 32'(overflow), 32'd0);
    end
    check_output("t3 empty", 32'(ready), 32'd0);

    for (int b = 1; b <= 8; b++) send_frame(8'(b), 1'b0, 11, 1'b0);
    send_frame(8'h09, 1'b0, 11, 1'b1);
    check_output("t4 overflow", 32'(overflow), 32'd0);
    for (int i = 2; i <= 9; i++) begin
      check_output("t4 drain data", 32'(data), 32'(i));
      do_pop();
    end
    check_output("t4 empty", 32'(ready), 32'd0);

    base = n_ferr;
    send_frame(8'h00, 1'b0, 5, 1'b0);
    tick(TIMEOUT + 10);
    #1;
    check_output("t5 timeout pulses", 32'(n_ferr - base), 32'd1);
    send_frame(8'h5A, 1'b0, 11, 1'b0);
    check_output("t5 data", 32'(data), 32'h5A);
    do_pop();

    send_frame(8'h77, 1'b0, 6, 1'b0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    check_output("t6 ready", 32'(ready), 32'd0);
    check_output("t6 overflow", 32'(overflow), 32'd0);
    check_output("t6 sampling", 32'(sampling), 32'd0);
    check_output("t6 frame_err", 32'(frame_err), 32'd0);
    send_frame(8'h29, 1'b0, 11, 1'b0);
    check_output("t6 ready after frame", 32'(ready), 32'd1);
    check_output("t6 data", 32'(data), 32'h29);

    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

PS/2 device-to-host receiver with an integrated show-ahead byte FIFO. It is the stage directly upstream of the keyboard FSM/display logic. It synchronizes the raw `ps2_clk`/`ps2_data` lines, deframes 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop), and discards malformed or stalled frames. Valid scan-code bytes are queued for a consumer that uses a `ready`/`nextdata_n` handshake.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, minimum 2.
- `TIMEOUT`, 4096: clk cycles without a ps2_clk falling edge, mid-frame, before the partial frame is aborted.
- `clk`  input  1  system clock; all logic on posedge.
- `clr`  input  1  synchronous, active-high reset.
- `ps2_clk`  input  1  raw PS/2 clock; asynchronous.
- `ps2_data`  input  1  raw PS/2 data; asynchronous.
- `nextdata_n`  input  1  active-low pop request, sampled on posedge clk.
- `data`  output  8  head-of-FIFO byte (show-ahead); valid only while `ready`=1.
- `ready`  output  1  FIFO not empty.
- `overflow`  output  1  sticky flag: a valid byte was dropped because the FIFO was full.
- `sampling`  output  1  one-cycle pulse on every accepted ps2_clk falling edge.
- `frame_err`  output  1  one-cycle pulse when a frame is discarded (bad start, parity, or stop bit, or timeout).

## Operation
- Synchronizer: `ps2_clk` and `ps2_data` each pass through 2 flip-flops. A third ps2_clk stage feeds edge detection.
- Falling edge: previous synced clk = 1 and current synced clk = 0. On that edge, sample synced data into bit slot `cnt` (0..10), increment `cnt`, and pulse `sampling`.
- Receiver states:
  - IDLE (`cnt`=0).
  - RECV (0<`cnt`<11).
  - On the 11th sample, evaluate the frame in the same cycle and return to IDLE.
- Frame valid when all hold: bit0 = 0, bit10 = 1, and XOR of bits1..9 = 1 (odd parity). Data byte = bits8..1, where bit1 is the LSB.
- Valid frame: byte written to FIFO at write pointer.
- Invalid frame: byte discarded, `frame_err` pulses, no FIFO change.
- Timeout: a watchdog counter clears on each falling edge and counts while in RECV. When it reaches `TIMEOUT`:
  - `cnt` returns to 0 and `frame_err` pulses.
  - The next falling edge is treated as a start bit.
- FIFO: read and write pointers are log2(DEPTH)+1 bits; wrap modulo 2·DEPTH.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
- Pop: on posedge with `nextdata_n`=0 and `ready`=1, the read pointer advances. A pop on an empty FIFO is ignored.
- Write when full:
  - With a pop in the same cycle: both pop and write happen, count unchanged, no overflow.
  - Without a pop: byte dropped and `overflow` set.
- `overflow` clears on the next successful pop or on `clr`.
- `clr`: pointers, `cnt`, watchdog, synchronizer stages (to 1), `overflow`, and pulses all cleared. FIFO contents need no reset. A frame in progress at `clr` is lost.

## Timing
- Reset values: `ready`=0, `overflow`=0, `sampling`=0, `frame_err`=0. `data` is don't-care while `ready`=0.
- Edge latency: a ps2_clk fall at the pins shows up as `sampling`=1 on the 3rd posedge after it settles.
- Write latency: the 11th `sampling` pulse is in cycle N. In cycle N+1, `ready`=1 (if previously empty) and `data` = new byte. `frame_err`, if any, is high in cycle N+1 only.
- `data` changes on the posedge following a pop. `ready` drops on that same posedge if the last entry was popped.
- A consumer holding `nextdata_n`=0 continuously drains one byte per cycle.
- `sampling` and `frame_err` are exactly one cycle wide.

## Test plan
- Reset, then frame 0x1C. Bits are 0, 0,0,1,1,1,0,0,0, parity 0, stop 1; each half-period of ps2_clk is 20 clk cycles. Expect 11 `sampling` pulses; `ready`=1 and `data`=0x1C one cycle after the last pulse. Then a 1-cycle `nextdata_n`=0 gives `ready`=0.
- Frame 0x1C with parity bit 1 → `frame_err` pulse; `ready` stays 0. The following valid frame 0xF0 → `data`=0xF0.
- Nine valid frames 0x01..0x09 with no pops (DEPTH=8) → `overflow`=1 after the 9th. Draining returns 0x01..0x08 in order. `overflow` clears on the first pop.
- FIFO full; the 9th frame completes in the same cycle as a pop → no overflow. Draining yields 0x02..0x09.
- Drive 5 falling edges, then hold ps2_clk high for `TIMEOUT`+10 cycles → one `frame_err` pulse. A subsequent frame 0x5A → `data`=0x5A.
- Assert `clr` for one cycle after the 6th bit of a frame → all outputs 0. The next complete frame 0x29 → `data`=0x29, `ready`=1.
